// File: rtl/mux_n_scan.sv
// CHANNELS:1 WIDTH-bit multiplexer with a registered output and a valid/ready output handshake.
// In direct mode the external select chooses the channel; in scan mode an internal pointer visits each channel for DWELL words.
module mux_n_scan #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 5,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [CHANNELS*WIDTH-1:0] in_i,
    input  logic [SEL_W-1:0]          sel_i,
    input  logic                      mode_i,
    input  logic                      ready_i,
    output logic [WIDTH-1:0]          m_o,
    output logic [SEL_W-1:0]          chan_o,
    output logic                      valid_o,
    output logic                      err_o
);

    localparam logic [SEL_W:0]   NUM_CH  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [7:0]       LAST_DW = 8'(DWELL - 1);

    logic [WIDTH-1:0] m_q, m_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [7:0]       dwell_q, dwell_d;
    logic             mode_q;

    logic             load;
    logic             modeRise;
    logic [SEL_W-1:0] ptrEff;
    logic [7:0]       dwellEff;

    // A select value at or above CHANNELS never matches, so out-of-range yields zero.
    function automatic logic [WIDTH-1:0] pickChannel(input logic [CHANNELS*WIDTH-1:0] data,
                                                     input logic [SEL_W-1:0] idx);
        logic [WIDTH-1:0] result;
        result = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) result = data[k*WIDTH +: WIDTH];
        end
        return result;
    endfunction

    always_comb begin
        load     = !valid_q || ready_i;
        modeRise = mode_i && !mode_q;
        ptrEff   = modeRise ? '0 : ptr_q;
        dwellEff = modeRise ? '0 : dwell_q;

        m_d     = m_q;
        chan_d  = chan_q;
        err_d   = err_q;
        valid_d = valid_q;
        ptr_d   = ptrEff;
        dwell_d = dwellEff;

        if (load) begin
            valid_d = 1'b1;
            if (mode_i) begin
                m_d    = pickChannel(in_i, ptrEff);
                chan_d = ptrEff;
                err_d  = 1'b0;
                if (dwellEff == LAST_DW) begin
                    dwell_d = '0;
                    ptr_d   = (ptrEff == LAST_CH) ? '0 : ptrEff + 1'b1;
                end else begin
                    dwell_d = dwellEff + 8'd1;
                end
            end else if ({1'b0, sel_i} >= NUM_CH) begin
                m_d    = '0;
                chan_d = sel_i;
                err_d  = 1'b1;
            end else begin
                m_d    = pickChannel(in_i, sel_i);
                chan_d = sel_i;
                err_d  = 1'b0;
            end
        end
    end

    // The mode register tracks the input every cycle, including stalls, so edges are never missed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_q     <= '0;
            chan_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            m_q     <= m_d;
            chan_q  <= chan_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_i;
        end
    end

    assign m_o     = m_q;
    assign chan_o  = chan_q;
    assign err_o   = err_q;
    assign valid_o = valid_q;

endmodule
